// File: rtl/qbus_pkg.sv
// Shared types and constants for the Qbus DMA master.
package qbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_GRANT, ST_ADDR, ST_DATA, ST_REPLY, ST_END, ST_DONE
  } state_e;

  localparam logic [21:0] IO_PAGE_BASE    = 22'o17760000;
  localparam int          DEF_SETUP_CYC   = 8;
  localparam int          DEF_TIMEOUT_CYC = 1000;

  // Registered open-drain gate drives, 1 = line asserted.
  typedef struct packed {
    logic bsync;
    logic bdin;
    logic bdout;
    logic bwtbt;
    logic bbs7;
    logic bdmr;
    logic bsack;
    logic bdmgo;
  } gdrv_t;

  function automatic logic in_io_page(input logic [21:0] addr);
    return (addr & IO_PAGE_BASE) == IO_PAGE_BASE;
  endfunction

endpackage

// File: rtl/qbus_sync.sv
// Two-flop synchronizer for active-low bus inputs; resets to the negated level.
module qbus_sync #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/qbus_dma_master.sv
// Qbus DMA master: one DATI/DATO/DATOB transfer per bus tenure.
// Define QBUS_DMA_TIMEOUT_EN to abort a cycle when BRPLY never arrives.
module qbus_dma_master
  import qbus_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_byte,
  input  logic [21:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [15:0] rsp_data,
  input  logic [21:0] BDALf_IN,
  output logic [21:0] BDALf_OUT,
  output logic [21:0] BDALf_OE,
  output logic        Outbound,
  input  logic        BSYNCf,
  input  logic        BRPLYf,
  input  logic        BDMGIf,
  input  logic        BINITf,
  output logic        BSYNCg,
  output logic        BDINg,
  output logic        BDOUTg,
  output logic        BWTBTg,
  output logic        BBS7g,
  output logic        BDMRg,
  output logic        BSACKg,
  output logic        BDMGOg
);

  localparam int SW = $clog2(SETUP_CYC + 1);

  logic [3:0] sync_s;
  logic       bsync_s, brply_s, bdmgi_s, binit_s, accept_s;

  state_e      state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  gdrv_t       g_q, g_d;
  logic [21:0] out_q, out_d, oe_q, oe_d;
  logic        outbound_q, rdy_q;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [21:0] addr_q;
  logic [15:0] data_q;
  logic        write_q, byte_q;
  logic        unused_bdal_hi;

`ifdef QBUS_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
`endif

  qbus_sync #(.W(4)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   ({BSYNCf, BRPLYf, BDMGIf, BINITf}),
    .q_o   (sync_s)
  );

  assign bsync_s        = ~sync_s[3];
  assign brply_s        = ~sync_s[2];
  assign bdmgi_s        = ~sync_s[1];
  assign binit_s        = ~sync_s[0];
  assign cmd_ready      = rdy_q & ~binit_s;
  assign accept_s       = (state_q == ST_IDLE) && cmd_valid && cmd_ready;
  assign unused_bdal_hi = ^BDALf_IN[21:16];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    g_d         = g_q;
    g_d.bdmgo   = 1'b0;
    out_d       = out_q;
    oe_d        = oe_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_data_d  = 16'h0000;
`ifdef QBUS_DMA_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_REQ;
          g_d.bdmr = 1'b1;
`ifdef QBUS_DMA_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end else begin
          g_d.bdmgo = bdmgi_s && !cmd_valid;
        end
      end
      ST_REQ: begin
        if (bdmgi_s) begin
          state_d   = ST_GRANT;
          g_d.bdmr  = 1'b0;
          g_d.bsack = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!bsync_s && !brply_s) begin
          state_d   = ST_ADDR;
          out_d     = addr_q;
          oe_d      = 22'h3FFFFF;
          g_d.bbs7  = in_io_page(addr_q);
          g_d.bwtbt = write_q;
          cnt_d     = '0;
        end
      end
      ST_ADDR: begin
        if (cnt_q == SW'(SETUP_CYC - 1)) begin
          state_d   = ST_DATA;
          g_d.bsync = 1'b1;
          g_d.bbs7  = 1'b0;
          cnt_d     = '0;
`ifdef QBUS_DMA_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
          if (write_q) begin
            out_d     = {6'b000000, data_q};
            oe_d      = 22'h00FFFF;
            g_d.bwtbt = byte_q;
          end else begin
            out_d     = 22'h000000;
            oe_d      = 22'h000000;
            g_d.bwtbt = 1'b0;
            g_d.bdin  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_DATA: begin
        // Writes first hold data for the setup time before strobing BDOUT.
        if (write_q && !g_q.bdout) begin
          if (cnt_q == SW'(SETUP_CYC - 1)) begin
            g_d.bdout = 1'b1;
`ifdef QBUS_DMA_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end else if (brply_s) begin
          state_d = ST_REPLY;
          cnt_d   = '0;
          if (write_q) begin
            g_d.bdout = 1'b0;
            out_d     = 22'h000000;
            oe_d      = 22'h000000;
          end
`ifdef QBUS_DMA_TIMEOUT_EN
        end else if (to_cnt_q == TW'(TIMEOUT_CYC)) begin
          state_d   = ST_END;
          err_d     = 1'b1;
          g_d.bdin  = 1'b0;
          g_d.bdout = 1'b0;
          g_d.bsync = 1'b0;
          g_d.bwtbt = 1'b0;
          out_d     = 22'h000000;
          oe_d      = 22'h000000;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
`endif
        end
      end
      ST_REPLY: begin
        // Reads wait out the deskew time before sampling slave data.
        if (g_q.bdin) begin
          if (cnt_q == SW'(SETUP_CYC - 1)) begin
            rdata_d  = ~BDALf_IN[15:0];
            g_d.bdin = 1'b0;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end else if (!brply_s) begin
          state_d   = ST_END;
          g_d.bsync = 1'b0;
          g_d.bwtbt = 1'b0;
          out_d     = 22'h000000;
          oe_d      = 22'h000000;
        end
      end
      ST_END: begin
        state_d     = ST_DONE;
        g_d.bsack   = 1'b0;
        rsp_valid_d = 1'b1;
`ifdef QBUS_DMA_TIMEOUT_EN
        rsp_error_d = err_q;
        rsp_data_d  = (write_q || err_q) ? 16'h0000 : rdata_q;
`else
        rsp_data_d  = write_q ? 16'h0000 : rdata_q;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && binit_s) begin
      state_d     = ST_IDLE;
      g_d         = '0;
      out_d       = 22'h000000;
      oe_d        = 22'h000000;
      rsp_valid_d = 1'b1;
      rsp_error_d = 1'b1;
      rsp_data_d  = 16'h0000;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      g_q         <= '0;
      out_q       <= 22'h000000;
      oe_q        <= 22'h000000;
      outbound_q  <= 1'b0;
      rdy_q       <= 1'b0;
      rdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      addr_q      <= 22'h000000;
      data_q      <= 16'h0000;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      g_q         <= g_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      outbound_q  <= |oe_d;
      rdy_q       <= (state_d == ST_IDLE);
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      if (accept_s) begin
        addr_q  <= cmd_addr;
        data_q  <= cmd_data;
        write_q <= cmd_write;
        byte_q  <= cmd_write & cmd_byte;
      end
    end
  end

`ifdef QBUS_DMA_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
`endif

  assign BDALf_OUT = out_q;
  assign BDALf_OE  = oe_q;
  assign Outbound  = outbound_q;
  assign BSYNCg    = g_q.bsync;
  assign BDINg     = g_q.bdin;
  assign BDOUTg    = g_q.bdout;
  assign BWTBTg    = g_q.bwtbt;
  assign BBS7g     = g_q.bbs7;
  assign BDMRg     = g_q.bdmr;
  assign BSACKg    = g_q.bsack;
  assign BDMGOg    = g_q.bdmgo;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_qbus_dma_master.sv
// Scoreboard bench for qbus_dma_master with a behavioral arbiter and slave.
module tb_qbus_dma_master;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_byte = 1'b0;
  logic [21:0] cmd_addr = 22'h0;
  logic [15:0] cmd_data = 16'h0;
  logic        rsp_valid, rsp_error;
  logic [15:0] rsp_data;
  logic [21:0] BDALf_IN, BDALf_OUT, BDALf_OE, bus_true;
  logic        Outbound, BSYNCf, BRPLYf, BDMGIf, BINITf;
  logic        BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg;

  logic        s_brply = 1'b0, slave_oe = 1'b0, slave_present = 1'b1;
  logic [15:0] slave_val = 16'h0, slave_data = 16'h0, sl_wdata = 16'h0;
  logic        sl_wbt = 1'b0;
  int          rd_delay = 3, sl_st = 0, sl_cnt = 0;
  logic        bdmgi = 1'b0, binit = 1'b0, arb_en = 1'b1;
  int          arb_cnt = 0;

  logic        o_bdmr, o_bsack, o_leak, o_bbs7, o_abt, o_dbt;
  logic [21:0] o_addr;
  logic [15:0] o_wdata;
  int          o_bdin_len;
  logic        p_bsync = 1'b0, p_bdout = 1'b0, p_bbs7 = 1'b0, p_bwtbt = 1'b0;
  logic [21:0] p_out = 22'h0, p_oe = 22'h0;

  rsp_t        exp_q[$];
  int          n_cmp = 0, n_err = 0, n_rsp = 0;

  assign bus_true = (BDALf_OE & BDALf_OUT) |
                    (~BDALf_OE & (slave_oe ? {6'b000000, slave_val} : 22'h000000));
  assign BDALf_IN = ~bus_true;
  assign BSYNCf   = ~BSYNCg;
  assign BRPLYf   = ~s_brply;
  assign BDMGIf   = ~bdmgi;
  assign BINITf   = ~binit;

  qbus_dma_master #(.SETUP_CYC(4), .TIMEOUT_CYC(50)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_byte(cmd_byte), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data),
    .BDALf_IN(BDALf_IN), .BDALf_OUT(BDALf_OUT), .BDALf_OE(BDALf_OE),
    .Outbound(Outbound), .BSYNCf(BSYNCf), .BRPLYf(BRPLYf), .BDMGIf(BDMGIf),
    .BINITf(BINITf), .BSYNCg(BSYNCg), .BDINg(BDINg), .BDOUTg(BDOUTg),
    .BWTBTg(BWTBTg), .BBS7g(BBS7g), .BDMRg(BDMRg), .BSACKg(BSACKg),
    .BDMGOg(BDMGOg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic clear_obs();
    o_bdmr = 1'b0; o_bsack = 1'b0; o_leak = 1'b0; o_bbs7 = 1'b0;
    o_abt = 1'b0; o_dbt = 1'b0; o_addr = 22'h0; o_wdata = 16'h0; o_bdin_len = 0;
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic issue(input logic w, input logic b, input logic [21:0] a, input logic [15:0] d);
    logic acc = 1'b0;
    int   k = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_byte = b; cmd_addr = a; cmd_data = d;
    while (!acc && k < 100) begin
      acc = cmd_ready;
      @(posedge clock);
      @(negedge clock);
      k++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int k = 0;
    while (n_rsp < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("rsp_arrived", n_rsp, target);
  endtask

  // Response monitor / scoreboard.
  initial forever begin
    @(negedge clock);
    if (rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_rsp: got err=%0d data=%h, required no response", rsp_error, rsp_data);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
        chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
      end
    end
  end

  // Bus observer: records what was on the lines at each phase boundary.
  initial forever begin
    @(negedge clock);
    if (BDMRg) o_bdmr = 1'b1;
    if (BSACKg) o_bsack = 1'b1;
    if (o_bdmr && BDMGOg) o_leak = 1'b1;
    if (BSYNCg && !p_bsync) begin
      o_addr = p_out & p_oe; o_bbs7 = p_bbs7; o_abt = p_bwtbt;
    end
    if (BDOUTg && !p_bdout) begin
      o_wdata = p_out[15:0] & p_oe[15:0]; o_dbt = BWTBTg;
    end
    if (BDINg) o_bdin_len++;
    p_bsync = BSYNCg; p_bdout = BDOUTg; p_bbs7 = BBS7g; p_bwtbt = BWTBTg;
    p_out = BDALf_OUT; p_oe = BDALf_OE;
  end

  // Arbiter: grants some cycles after BDMR, withdraws on BSACK.
  initial forever begin
    @(negedge clock);
    if (arb_en) begin
      if (BSACKg) begin
        bdmgi = 1'b0; arb_cnt = 0;
      end else if (BDMRg) begin
        arb_cnt++;
        if (arb_cnt >= 2) bdmgi = 1'b1;
      end
    end
  end

  // Slave: replies to DATI after rd_delay cycles, to DATO after 2.
  initial forever begin
    @(negedge clock);
    if (binit || reset) begin
      s_brply = 1'b0; slave_oe = 1'b0; sl_st = 0;
    end else begin
      case (sl_st)
        0: if (slave_present && BDINg) begin
             sl_cnt = 0; sl_st = 1;
           end else if (slave_present && BDOUTg) begin
             sl_wdata = bus_true[15:0]; sl_wbt = BWTBTg; sl_cnt = 0; sl_st = 3;
           end
        1: begin
             sl_cnt++;
             if (sl_cnt >= rd_delay) begin
               slave_val = slave_data; slave_oe = 1'b1; s_brply = 1'b1; sl_st = 2;
             end
           end
        2: if (!BDINg) begin slave_oe = 1'b0; s_brply = 1'b0; sl_st = 0; end
        3: begin
             sl_cnt++;
             if (sl_cnt >= 2) begin s_brply = 1'b1; sl_st = 4; end
           end
        4: if (!BDOUTg) begin s_brply = 1'b0; sl_st = 0; end
        default: sl_st = 0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_gdrv", {24'b0, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg}, 32'd0);
    chk("rst_oe", {10'b0, BDALf_OE}, 32'd0);
    chk("rst_out", {10'b0, BDALf_OUT}, 32'd0);
    chk("rst_misc", {28'b0, Outbound, cmd_ready, rsp_valid, rsp_error}, 32'd0);
    chk("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Grant passes downstream while idle, is blocked once a command arrives.
    arb_en = 1'b0; bdmgi = 1'b1;
    repeat (2) @(negedge clock);
    chk("bdmgo_sync_lat", {31'b0, BDMGOg}, 32'd0);
    @(negedge clock);
    chk("bdmgo_pass", {31'b0, BDMGOg}, 32'd1);
    arb_en = 1'b1; slave_data = 16'h5A5A; rd_delay = 3; clear_obs();
    exp_q.push_back({1'b0, 16'h5A5A});
    issue(1'b0, 1'b0, 22'o000100, 16'h0);
    chk("bdmgo_blocked", {31'b0, BDMGOg}, 32'd0);
    chk("bdmr_taken", {31'b0, BDMRg}, 32'd1);
    wait_rsp(1, 300);
    chk("grant_no_leak", {31'b0, o_leak}, 32'd0);

    // DATI in low memory, slow slave.
    slave_data = 16'h1234; rd_delay = 20; clear_obs();
    exp_q.push_back({1'b0, 16'h1234});
    issue(1'b0, 1'b0, 22'o001000, 16'h0);
    wait_rsp(2, 300);
    chk("dati_bdmr", {31'b0, o_bdmr}, 32'd1);
    chk("dati_bsack", {31'b0, o_bsack}, 32'd1);
    chk("dati_bbs7", {31'b0, o_bbs7}, 32'd0);
    chk("dati_addr", {10'b0, o_addr}, {10'b0, 22'o001000});
    chk("dati_wtbt", {31'b0, o_abt}, 32'd0);
    chk("dati_no_leak", {31'b0, o_leak}, 32'd0);

    // DATOB into the I/O page.
    clear_obs();
    exp_q.push_back({1'b0, 16'h0000});
    issue(1'b1, 1'b1, 22'o17772153, 16'hAB00);
    wait_rsp(3, 300);
    chk("datob_addr", {10'b0, o_addr}, {10'b0, 22'o17772153});
    chk("datob_bbs7", {31'b0, o_bbs7}, 32'd1);
    chk("datob_wtbt_addr", {31'b0, o_abt}, 32'd1);
    chk("datob_wtbt_data", {31'b0, o_dbt}, 32'd1);
    chk("datob_bdal_pre", {16'b0, o_wdata}, 32'h0000AB00);
    chk("datob_slave_data", {16'b0, sl_wdata}, 32'h0000AB00);

    // DATI with no slave present.
    slave_present = 1'b0; clear_obs();
    exp_q.push_back({1'b1, 16'h0000});
    issue(1'b0, 1'b0, 22'o002000, 16'h0);
`ifdef QBUS_DMA_TIMEOUT_EN
    wait_rsp(4, 300);
    chk("to_bdin_len", {31'b0, (o_bdin_len >= 50 && o_bdin_len <= 52)}, 32'd1);
`else
    repeat (200) @(negedge clock);
    chk("hang_no_rsp", n_rsp, 32'd3);
    chk("hang_bdin_held", {31'b0, BDINg}, 32'd1);
    binit = 1'b1;
    @(negedge clock);
    binit = 1'b0;
    wait_rsp(4, 50);
`endif
    chk("nosl_bdin_off", {31'b0, BDINg}, 32'd0);

    // BINIT pulse while a write is waiting for its reply.
    clear_obs();
    exp_q.push_back({1'b1, 16'h0000});
    issue(1'b1, 1'b0, 22'o000200, 16'hBEEF);
    for (int k = 0; k < 100 && !BDOUTg; k++) @(negedge clock);
    chk("binit_bdout_seen", {31'b0, BDOUTg}, 32'd1);
    binit = 1'b1;
    @(negedge clock);
    binit = 1'b0;
    @(negedge clock);
    chk("binit_pre_release", {31'b0, BDOUTg}, 32'd1);
    @(negedge clock);
    chk("binit_gdrv", {24'b0, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg}, 32'd0);
    chk("binit_oe", {9'b0, Outbound, BDALf_OE}, 32'd0);
    wait_rsp(5, 20);

    // Normal word write after the abort.
    slave_present = 1'b1; clear_obs();
    exp_q.push_back({1'b0, 16'h0000});
    issue(1'b1, 1'b0, 22'o000400, 16'h00C3);
    wait_rsp(6, 300);
    chk("post_binit_data", {16'b0, sl_wdata}, 32'h000000C3);
    chk("post_binit_wtbt", {31'b0, sl_wbt}, 32'd0);

    repeat (5) @(negedge clock);
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("rsp_total", n_rsp, 32'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qbus_dma_master.md
QBUS_DMA_MASTER -- requirements
Module: qbus_dma_master

Interface
REQ-001 Parameter SETUP_CYC, default 8: clock cycles of address setup, data setup and read deskew (at least 2).
REQ-002 Parameter TIMEOUT_CYC, default 1000: clock cycles to wait for BRPLY before abort.
REQ-003 One clock, asynchronous active-high reset: clock  in  1  system clock; reset  in  1  asynchronous active-high reset.
REQ-004 cmd_valid  in  1  requester has a DMA command; cmd_ready  out  1  command accepted this cycle when both high.
REQ-005 cmd_write  in  1  1 = DATO/DATOB, 0 = DATI; cmd_byte  in  1  byte write (DATOB); ignored for reads.
REQ-006 cmd_addr  in  22  Qbus byte address; cmd_data  in  16  write data, lane placement by requester.
REQ-007 rsp_valid  out  1  one-cycle completion pulse; rsp_error  out  1  timeout or BINIT abort, valid with rsp_valid.
REQ-008 rsp_data  out  16  read data, valid with rsp_valid, 0 for writes and errors.
REQ-009 BDALf_IN  in  22  bus BDAL, inverted level; BDALf_OUT  out  22  true-sense drive value; BDALf_OE  out  22  per-bit FPGA drive enable.
REQ-010 Outbound  out  1  BDAL gate-driver enable, 1 whenever BDALf_OE is nonzero.
REQ-011 BSYNCf, BRPLYf, BDMGIf, BINITf  in  1 each  bus lines, low = asserted, asynchronous.
REQ-012 BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg  out  1 each  MOSFET gate drives, 1 = assert line.

Function
REQ-013 All *f inputs shall pass through two-flop synchronizers; "asserted" below means synchronized value low.
REQ-014 All *g outputs, BDALf_OUT/OE and Outbound shall be registered.
REQ-015 cmd_ready shall be 1 only in IDLE with BINIT negated; command fields are captured on the accepting edge.
REQ-016 States: IDLE, REQ, GRANT, ADDR, DATA, REPLY, END, DONE.
REQ-017 IDLE -> REQ on accept; REQ asserts BDMRg, stays until BDMGI asserted.
REQ-018 REQ -> GRANT: assert BSACKg, negate BDMRg, wait until BSYNC and BRPLY both negated, then -> ADDR.
REQ-019 ADDR: drive cmd_addr on BDAL[21:0]; BBS7g = (cmd_addr[21:13] all ones); BWTBTg = cmd_write; hold SETUP_CYC cycles, then assert BSYNCg, -> DATA.
REQ-020 DATA read: BDAL released, BBS7g/BWTBTg negated, BDINg asserted, timeout counter started.
REQ-021 DATA write: drive cmd_data on BDAL[15:0] (BDAL[21:16] released), BWTBTg = cmd_byte, hold SETUP_CYC, then assert BDOUTg, start counter.
REQ-022 DATA -> REPLY on BRPLY asserted; read latches ~BDALf_IN[15:0] SETUP_CYC cycles after BRPLY seen, then negates BDINg; write negates BDOUTg and releases BDAL immediately.
REQ-023 REPLY -> END when BRPLY negated: negate BSYNCg, BWTBTg, BDAL.
REQ-024 END -> DONE: negate BSACKg; DONE pulses rsp_valid one cycle, -> IDLE; one transfer per bus tenure.
REQ-025 BDMGOg = BDMGI asserted && state IDLE && !cmd_valid; grant shall never pass downstream once BDMRg has been asserted.
REQ-026 Timeout counter saturates at TIMEOUT_CYC; at expiry negate BDIN/BDOUT, -> END with rsp_error=1, rsp_data=0.
REQ-027 BRPLY arriving on the expiry cycle shall count as a reply (no error).
REQ-028 BINIT asserted in any non-IDLE state: next cycle all g outputs and BDAL enables negated, -> IDLE, rsp_valid pulse with rsp_error=1.

Reset
REQ-029 While reset=1: state IDLE; all g outputs, BDALf_OUT, BDALf_OE, Outbound, cmd_ready, rsp_* = 0; counters 0; synchronizers cleared to negated (1).

Configuration
REQ-030 With QBUS_DMA_TIMEOUT_EN defined, REQ-026/027 apply; without it, no counter exists, DATA waits for BRPLY indefinitely and rsp_error is set only by BINIT.

Structure
REQ-031 Package qbus_pkg: state enum, IO-page base 22'o17760000, default SETUP_CYC/TIMEOUT_CYC.
REQ-032 Sub-module qbus_sync (parameterized-width two-flop synchronizer), instanced for the four bus inputs.

Verification
REQ-033 DATI addr 22'o001000, slave replies 0x1234 after 20 cycles -> BDMR, BSACK, BBS7=0, rsp_data 0x1234, rsp_error 0.
REQ-034 DATOB addr 22'o17772153, data 0xAB00 -> BBS7=1, BWTBT high in both ADDR and DATA, BDAL[15:0]=0xAB00 before BDOUT.
REQ-035 DATI with no slave, TIMEOUT_CYC=50 -> BDIN negated ~50 cycles after assertion, rsp_error 1, rsp_data 0; undefined macro -> hang until BINIT.
REQ-036 BDMGI asserted while idle with no command -> BDMGOg 1 after synchronizer latency; with cmd_valid high -> BDMGOg stays 0, BDMR taken.
REQ-037 BINIT pulse during DATA of a write -> all drives released next cycle, rsp_valid with rsp_error 1, next command accepted normally.
